execute_writeback: RTL and testbench

EXECUTE_WRITEBACK -- requirements
Module: execute_writeback

---
 rtl/execute_writeback.sv | 187 ++++++++++++++++++
 tb/tb_execute_writeback.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/execute_writeback.sv
// Execute + write-back stage: ALU, branch resolution, 32-word data memory, registered regfile write port.
// Optional operand forwarding from WB into EX is enabled by defining EXECUTE_FORWARDING_EN.
module execute_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [4:0]  in_rr1,
    input  logic [4:0]  in_rr2,
    input  logic [31:0] imm,
    input  logic [4:0]  in_write_reg,
    input  logic        in_reg_wrenable,
    input  logic [3:0]  jump_type,
    input  logic        mem_wrenable,
    input  logic        mem_to_reg,
    input  logic        alu_src,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  in_pc,
    output logic [4:0]  jump_pc,
    output logic        should_jump,
    output logic [4:0]  out_write_reg,
    output logic [31:0] write_data,
    output logic        out_reg_wrenable
);

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            5'd0:    alu_f = a + b;
            5'd1:    alu_f = a - b;
            5'd2:    alu_f = a & b;
            5'd3:    alu_f = a | b;
            5'd4:    alu_f = a ^ b;
            5'd5:    alu_f = a << b[4:0];
            5'd6:    alu_f = a >> b[4:0];
            5'd7:    alu_f = sa >>> b[4:0];
            5'd8:    alu_f = {31'b0, sa < sb};
            5'd9:    alu_f = {31'b0, a < b};
            5'd10:   alu_f = b;
            default: alu_f = '0;
        endcase
    endfunction

    function automatic logic taken_f(input logic [3:0] jt, input logic [31:0] a,
                                     input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (jt)
            4'd1:       taken_f = (a == b);
            4'd2:       taken_f = (a != b);
            4'd3:       taken_f = (sa < sb);
            4'd4:       taken_f = (sa >= sb);
            4'd5:       taken_f = (a < b);
            4'd6:       taken_f = (a >= b);
            4'd7, 4'd8: taken_f = 1'b1;
            default:    taken_f = 1'b0;
        endcase
    endfunction

    // JALR target is the word index of (rs1 + imm), bits [6:2] of the byte address
    function automatic logic [4:0] jalr_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sum;
        sum = a + b;
        jalr_f = sum[6:2];
    endfunction

    // ---- EX register set (p1) ----
    logic        vld_p1_q, vld_p1_d;
    logic        wren_p1_q, wren_p1_d;
    logic        memwr_p1_q, memwr_p1_d;
    logic        memtoreg_p1_q, memtoreg_p1_d;
    logic [3:0]  jt_p1_q, jt_p1_d;
    logic [31:0] rs1_p1_q, rs2_p1_q, imm_p1_q;
    logic [4:0]  rd_p1_q, aluop_p1_q, pc_p1_q;
    logic        alusrc_p1_q;

    logic [31:0] mem_q [32];
    logic [31:0] opa, rs2_val, opb, alu_res, mem_rd, wb_data;
    logic [4:0]  mem_addr, pc_inc;
    logic        is_link, squash;

`ifdef EXECUTE_FORWARDING_EN
    logic [4:0] rr1_p1_q, rr2_p1_q;

    always_ff @(posedge clk) begin
        rr1_p1_q <= in_rr1;
        rr2_p1_q <= in_rr2;
    end

    // index 0 is hardwired; out_reg_wrenable is already 0 for rd 0 but keep the guard explicit
    assign opa     = (out_reg_wrenable && rr1_p1_q != 5'd0 && out_write_reg == rr1_p1_q)
                     ? write_data : rs1_p1_q;
    assign rs2_val = (out_reg_wrenable && rr2_p1_q != 5'd0 && out_write_reg == rr2_p1_q)
                     ? write_data : rs2_p1_q;
`else
    logic unused_rr;
    assign unused_rr = ^{in_rr1, in_rr2};
    assign opa       = rs1_p1_q;
    assign rs2_val   = rs2_p1_q;
`endif

    always_comb begin
        squash        = reset || should_jump;
        vld_p1_d      = !squash;
        wren_p1_d     = squash ? 1'b0 : in_reg_wrenable;
        memwr_p1_d    = squash ? 1'b0 : mem_wrenable;
        memtoreg_p1_d = squash ? 1'b0 : mem_to_reg;
        jt_p1_d       = squash ? 4'd0 : jump_type;
    end

    always_ff @(posedge clk) begin
        vld_p1_q      <= vld_p1_d;
        wren_p1_q     <= wren_p1_d;
        memwr_p1_q    <= memwr_p1_d;
        memtoreg_p1_q <= memtoreg_p1_d;
        jt_p1_q       <= jt_p1_d;
        rs1_p1_q      <= read_data1;
        rs2_p1_q      <= read_data2;
        imm_p1_q      <= imm;
        rd_p1_q       <= in_write_reg;
        aluop_p1_q    <= alu_op;
        alusrc_p1_q   <= alu_src;
        pc_p1_q       <= in_pc;
    end

    assign opb      = alusrc_p1_q ? imm_p1_q : rs2_val;
    assign alu_res  = alu_f(aluop_p1_q, opa, opb);
    assign mem_addr = alu_res[6:2];
    assign mem_rd   = mem_q[mem_addr];
    assign pc_inc   = pc_p1_q + 5'd1;
    assign is_link  = (jt_p1_q == 4'd7) || (jt_p1_q == 4'd8);

    always_comb begin
        should_jump = vld_p1_q && taken_f(jt_p1_q, opa, rs2_val);
        jump_pc     = '0;
        if (should_jump)
            jump_pc = (jt_p1_q == 4'd8) ? jalr_f(opa, imm_p1_q) : pc_p1_q + imm_p1_q[6:2];
    end

    // data memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (vld_p1_q && memwr_p1_q)
            mem_q[mem_addr] <= rs2_val;
    end

    always_comb begin
        if (memtoreg_p1_q)
            wb_data = mem_rd;
        else if (is_link)
            wb_data = {25'b0, pc_inc, 2'b00};
        else
            wb_data = alu_res;
    end

    // ---- WB register set (p2) ----
    logic [4:0]  rd_p2_q, rd_p2_d;
    logic [31:0] data_p2_q, data_p2_d;
    logic        wren_p2_q, wren_p2_d;

    always_comb begin
        rd_p2_d   = rd_p1_q;
        data_p2_d = wb_data;
        wren_p2_d = vld_p1_q && wren_p1_q && (rd_p1_q != 5'd0);
        if (reset) begin
            rd_p2_d   = '0;
            data_p2_d = '0;
            wren_p2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rd_p2_q   <= rd_p2_d;
        data_p2_q <= data_p2_d;
        wren_p2_q <= wren_p2_d;
    end

    assign out_write_reg    = rd_p2_q;
    assign write_data       = data_p2_q;
    assign out_reg_wrenable = wren_p2_q;

endmodule

// File: tb/tb_execute_writeback.sv
// Directed bench for execute_writeback: reset, ALU ops, branches/jumps with squash, load/store, reset mid-jump.
module tb_execute_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] read_data1, read_data2, imm;
    logic [4:0]  in_rr1, in_rr2, in_write_reg, alu_op, in_pc;
    logic        in_reg_wrenable, mem_wrenable, mem_to_reg, alu_src;
    logic [3:0]  jump_type;
    logic [4:0]  jump_pc, out_write_reg;
    logic        should_jump, out_reg_wrenable;
    logic [31:0] write_data;

    int vectors = 0;
    int errs    = 0;

    execute_writeback dut (
        .clk(clk), .reset(reset),
        .read_data1(read_data1), .read_data2(read_data2),
        .in_rr1(in_rr1), .in_rr2(in_rr2), .imm(imm),
        .in_write_reg(in_write_reg), .in_reg_wrenable(in_reg_wrenable),
        .jump_type(jump_type), .mem_wrenable(mem_wrenable), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .in_pc(in_pc),
        .jump_pc(jump_pc), .should_jump(should_jump),
        .out_write_reg(out_write_reg), .write_data(write_data),
        .out_reg_wrenable(out_reg_wrenable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic dec(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic wr, input logic [3:0] jt,
                       input logic mw, input logic m2r, input logic asrc, input logic [4:0] pc);
        alu_op = op; read_data1 = r1; read_data2 = r2; imm = im;
        in_rr1 = a1; in_rr2 = a2; in_write_reg = rd; in_reg_wrenable = wr;
        jump_type = jt; mem_wrenable = mw; mem_to_reg = m2r; alu_src = asrc; in_pc = pc;
    endtask

    task automatic nop();
        dec(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    logic [31:0] exp_add;

    initial begin
`ifdef EXECUTE_FORWARDING_EN
        exp_add = 32'd10;
`else
        exp_add = 32'd0;
`endif
        nop();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_sj", {31'b0, should_jump}, 32'd0);
        chk("rst_jpc", {27'b0, jump_pc}, 32'd0);
        chk("rst_rd", {27'b0, out_write_reg}, 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_we", {31'b0, out_reg_wrenable}, 32'd0);
        reset = 1'b0;

        // ADDI x1,x0,5 ; ADD x2,x1,x1 back to back
        dec(5'd0, 32'd0, 32'd0, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        dec(5'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd1);
        tick();
        chk("addi_rd", {27'b0, out_write_reg}, 32'd1);
        chk("addi_data", write_data, 32'd5);
        chk("addi_we", {31'b0, out_reg_wrenable}, 32'd1);
        nop();
        tick();
        chk("add_rd", {27'b0, out_write_reg}, 32'd2);
        chk("add_data", write_data, exp_add);

        // ALU patterns, one result per cycle
        dec(5'd7, 32'h8000_0000, 32'd4, 32'd0, 5'd20, 5'd21, 5'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd2);
        tick();
        dec(5'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd20, 5'd21, 5'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd3);
        tick();
        chk("sra", write_data, 32'hF800_0000);
        dec(5'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd20, 5'd21, 5'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd4);
        tick();
        chk("sltu", write_data, 32'd1);
        dec(5'd1, 32'd0, 32'd1, 32'd0, 5'd20, 5'd21, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd5);
        tick();
        chk("slt", write_data, 32'd1);
        nop();
        tick();
        chk("sub_wrap", write_data, 32'hFFFF_FFFF);
        chk("x0_we", {31'b0, out_reg_wrenable}, 32'd0);

        // store 0x0BADF00D at byte 0x20, then taken BEQ with a squashed store behind it
        dec(5'd0, 32'd0, 32'h0BAD_F00D, 32'h20, 5'd20, 5'd21, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 5'd3);
        tick();
        dec(5'd0, 32'd7, 32'd7, 32'd12, 5'd20, 5'd21, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 5'd4);
        tick();
        chk("beq_sj", {31'b0, should_jump}, 32'd1);
        chk("beq_jpc", {27'b0, jump_pc}, 32'd7);
        dec(5'd0, 32'd0, 32'h1234_5678, 32'h20, 5'd20, 5'd21, 5'd6, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 5'd5);
        tick();
        chk("bubble_sj", {31'b0, should_jump}, 32'd0);
        chk("beq_we", {31'b0, out_reg_wrenable}, 32'd0);
        dec(5'd0, 32'd0, 32'd0, 32'h20, 5'd20, 5'd21, 5'd9, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 5'd7);
        tick();
        chk("squash_we", {31'b0, out_reg_wrenable}, 32'd0);
        nop();
        tick();
        chk("squash_store", write_data, 32'h0BAD_F00D);
        chk("lw_rd", {27'b0, out_write_reg}, 32'd9);

        // BNE not taken, BLT signed taken, BLTU not taken
        dec(5'd0, 32'd7, 32'd7, 32'd12, 5'd20, 5'd21, 5'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 5'd5);
        tick();
        chk("bne_sj", {31'b0, should_jump}, 32'd0);
        chk("bne_jpc", {27'b0, jump_pc}, 32'd0);
        dec(5'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 5'd20, 5'd21, 5'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 5'd10);
        tick();
        chk("blt_sj", {31'b0, should_jump}, 32'd1);
        chk("blt_jpc", {27'b0, jump_pc}, 32'd12);
        nop();
        tick();
        dec(5'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 5'd20, 5'd21, 5'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 5'd12);
        tick();
        chk("bltu_sj", {31'b0, should_jump}, 32'd0);

        // JALR at pc 3, rs1=0x40, imm=4 ; JAL wrapping past pc 31
        dec(5'd0, 32'h40, 32'd0, 32'd4, 5'd20, 5'd21, 5'd7, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 5'd3);
        tick();
        chk("jalr_sj", {31'b0, should_jump}, 32'd1);
        chk("jalr_jpc", {27'b0, jump_pc}, 32'd17);
        nop();
        tick();
        chk("jalr_rd", {27'b0, out_write_reg}, 32'd7);
        chk("jalr_link", write_data, 32'h10);
        chk("jalr_we", {31'b0, out_reg_wrenable}, 32'd1);
        dec(5'd0, 32'd0, 32'd0, 32'd12, 5'd20, 5'd21, 5'd10, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 5'd30);
        tick();
        chk("jal_jpc", {27'b0, jump_pc}, 32'd1);
        nop();
        tick();
        chk("jal_link", write_data, 32'h7C);

        // SW 0xDEADBEEF to byte 8, then LW from 8
        dec(5'd0, 32'd0, 32'hDEAD_BEEF, 32'd8, 5'd20, 5'd21, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1);
        tick();
        dec(5'd0, 32'd0, 32'd0, 32'd8, 5'd20, 5'd21, 5'd8, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        nop();
        tick();
        chk("lw_data", write_data, 32'hDEAD_BEEF);
        chk("lw8_rd", {27'b0, out_write_reg}, 32'd8);

        // reset asserted while a taken branch sits in EX
        dec(5'd0, 32'd3, 32'd3, 32'd12, 5'd20, 5'd21, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 5'd4);
        tick();
        chk("pre_rst_sj", {31'b0, should_jump}, 32'd1);
        nop();
        reset = 1'b1;
        tick();
        chk("midrst_sj", {31'b0, should_jump}, 32'd0);
        chk("midrst_jpc", {27'b0, jump_pc}, 32'd0);
        chk("midrst_we", {31'b0, out_reg_wrenable}, 32'd0);
        chk("midrst_data", write_data, 32'd0);
        reset = 1'b0;
        tick();
        dec(5'd0, 32'd0, 32'd0, 32'd8, 5'd20, 5'd21, 5'd8, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        nop();
        tick();
        chk("mem_kept", write_data, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
